// File: rtl/trap_ctrl_pkg.sv
// Shared CSR addresses, FSM state type and trap-vector helper for the
// machine-mode trap controller.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] MCAUSE_MTI_DEFAULT = 32'h8000_0007;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_TRAP  = 2'd1,
        ST_REDIR = 2'd2,
        ST_RET   = 2'd3
    } trap_state_t;

    // Vectored mode only offsets interrupts; 4*cause wraps modulo 2^32.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic [29:0] idx,
                                                input logic        is_irq);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (is_irq && (mtvec[1:0] == 2'b01))
            return base + {idx, 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Core-side bundle of the trap controller: instruction/exception inputs,
// CSR access bus and fetch redirect outputs.
interface trap_ctrl_if;
    logic        instValid_i;
    logic [31:0] pc_i;
    logic        excPresent_i;
    logic [31:0] excCause_i;
    logic [31:0] trapInfo_i;
    logic        mret_i;
    logic        mtip_i;
    logic [11:0] csrAddr_i;
    logic        csrWe_i;
    logic [31:0] csrWdata_i;
    logic [31:0] csrRdata_o;
    logic        stall_o;
    logic        redirect_o;
    logic [31:0] redirectPc_o;
    logic        flush_o;

    modport master (
        output instValid_i, pc_i, excPresent_i, excCause_i, trapInfo_i,
               mret_i, mtip_i, csrAddr_i, csrWe_i, csrWdata_i,
        input  csrRdata_o, stall_o, redirect_o, redirectPc_o, flush_o
    );

    modport slave (
        input  instValid_i, pc_i, excPresent_i, excCause_i, trapInfo_i,
               mret_i, mtip_i, csrAddr_i, csrWe_i, csrWdata_i,
        output csrRdata_o, stall_o, redirect_o, redirectPc_o, flush_o
    );
endinterface

// File: rtl/trap_csr_file.sv
// Trap CSR storage and combinational read mux. The controller guarantees that
// write, latch, enter and return strobes never coincide.
module trap_csr_file
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        latch_i,
    input  logic [31:0] latch_pc_i,
    input  logic [31:0] latch_cause_i,
    input  logic [31:0] latch_val_i,
    input  logic        enter_i,
    input  logic        ret_i,
    input  logic        we_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mtip_i,
    output logic [31:0] rdata_o,
    output logic        mie_o,
    output logic        mtie_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [29:0] vec_idx_o
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        mtie_q, mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtie_d   = mtie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;

        if (we_i) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_d  = wdata_i[3];
                    mpie_d = wdata_i[7];
                end
                CSR_MIE:    mtie_d   = wdata_i[7];
                CSR_MTVEC:  mtvec_d  = {wdata_i[31:2], 1'b0, wdata_i[0]};
                CSR_MEPC:   mepc_d   = {wdata_i[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = wdata_i;
                CSR_MTVAL:  mtval_d  = wdata_i;
                default: ;
            endcase
        end

        if (latch_i) begin
            mepc_d   = latch_pc_i;
            mcause_d = latch_cause_i;
            mtval_d  = latch_val_i;
        end

        if (enter_i) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end

        if (ret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CSR_MSTATUS: rdata_o = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            CSR_MIE:     rdata_o = {24'd0, mtie_q, 7'd0};
            CSR_MTVEC:   rdata_o = mtvec_q;
            CSR_MEPC:    rdata_o = mepc_q;
            CSR_MCAUSE:  rdata_o = mcause_q;
            CSR_MTVAL:   rdata_o = mtval_q;
            CSR_MIP:     rdata_o = {24'd0, mtip_i, 7'd0};
            default:     rdata_o = '0;
        endcase
    end

    assign mie_o     = mie_q;
    assign mtie_o    = mtie_q;
    assign mtvec_o   = mtvec_q;
    assign mepc_o    = mepc_q;
    assign vec_idx_o = mcause_q[29:0];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: decides trap entry / MRET in RUN and sequences
// the stall, CSR status update and registered fetch redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MCAUSE_MTI  = MCAUSE_MTI_DEFAULT
) (
    input logic        clk_i,
    input logic        rst_i,
    trap_ctrl_if.slave bus
);

    trap_state_t state_q, state_d;
    logic        irq_q, irq_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        latch, enter, ret, csr_we;
    logic [31:0] latch_cause, latch_val;
    logic        mie, mtie;
    logic [31:0] mtvec, mepc;
    logic [29:0] vec_idx;
    logic        irq_pending;

    assign irq_pending = mie & mtie & bus.mtip_i;

    trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .latch_i       (latch),
        .latch_pc_i    (bus.pc_i),
        .latch_cause_i (latch_cause),
        .latch_val_i   (latch_val),
        .enter_i       (enter),
        .ret_i         (ret),
        .we_i          (csr_we),
        .addr_i        (bus.csrAddr_i),
        .wdata_i       (bus.csrWdata_i),
        .mtip_i        (bus.mtip_i),
        .rdata_o       (bus.csrRdata_o),
        .mie_o         (mie),
        .mtie_o        (mtie),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc),
        .vec_idx_o     (vec_idx)
    );

    always_comb begin
        state_d       = state_q;
        irq_d         = irq_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        latch         = 1'b0;
        latch_cause   = bus.excCause_i;
        latch_val     = bus.trapInfo_i;
        enter         = 1'b0;
        ret           = 1'b0;
        csr_we        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.instValid_i) begin
                    if (bus.excPresent_i) begin
                        latch   = 1'b1;
                        irq_d   = 1'b0;
                        state_d = ST_TRAP;
                    end else if (irq_pending) begin
                        latch       = 1'b1;
                        latch_cause = MCAUSE_MTI;
                        latch_val   = '0;
                        irq_d       = 1'b1;
                        state_d     = ST_TRAP;
                    end else if (bus.mret_i) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = mepc;
                        state_d       = ST_RET;
                    end else begin
                        csr_we = bus.csrWe_i;
                    end
                end
            end
            ST_TRAP: begin
                enter         = 1'b1;
                redirect_d    = 1'b1;
                redirect_pc_d = trap_target(mtvec, vec_idx, irq_q);
                state_d       = ST_REDIR;
            end
            ST_REDIR: state_d = ST_RUN;
            ST_RET: begin
                ret     = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            irq_q         <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            irq_q         <= irq_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.stall_o      = (state_q != ST_RUN);
    assign bus.redirect_o   = redirect_q;
    assign bus.flush_o      = redirect_q;
    assign bus.redirectPc_o = redirect_pc_q;

endmodule
